// File: rtl/seq_mul_responder.sv
// -----------------------------------------------------------------------------
// seq_mul_responder
//
// Iterative shift-add multiplier used as the responder of a start/done strobe
// handshake. On a start strobe in IDLE the two 2N-bit operands are latched.
// One shift-add step is then performed every CLK_DIV_MULTIPLIER clocks, and the
// low 2N bits of the product are returned together with a one-cycle done
// strobe. The low 2N bits of a two's-complement product do not depend on
// signedness, so the operands are handled as plain bit vectors.
//
// Parameters:
//   N                  base width; operands and product are 2*N bits wide
//   CLK_DIV_MULTIPLIER clock cycles per shift-add step (1 or more)
//
// Ports:
//   clk_i            system clock
//   rst_i            synchronous, active-high reset
//   MUL_Start_STRB_i start request, only sampled in IDLE
//   a_i, b_i         multiplicand / multiplier (2N bits, two's complement)
//   MUL_Done_STRB_o  one-cycle pulse; out_o is valid from this cycle on
//   busy_o           high while a multiplication is in progress
//   out_o            product, held until the next completion or reset
//
// Build option:
//   SEQ_MUL_EARLY_EXIT_EN  when defined, finish as soon as the remaining
//                          multiplier bits are all zero (data-dependent
//                          latency, identical products).
// -----------------------------------------------------------------------------
module seq_mul_responder #(
  parameter int N                  = 41,
  parameter int CLK_DIV_MULTIPLIER = 50
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           MUL_Start_STRB_i,
  input  logic [2*N-1:0] a_i,
  input  logic [2*N-1:0] b_i,
  output logic           MUL_Done_STRB_o,
  output logic           busy_o,
  output logic [2*N-1:0] out_o
);

  localparam int W      = 2 * N;
  localparam int STEP_W = $clog2(W + 1);
  localparam int DIV_W  = (CLK_DIV_MULTIPLIER > 1) ? $clog2(CLK_DIV_MULTIPLIER) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV_MULTIPLIER - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(W - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  state_t              state;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic [W-1:0]        acc;
  logic [STEP_W-1:0]   step_cnt;
  logic [DIV_W-1:0]    div_cnt;

  // Next-step values, shared by the ordinary step and the finishing step so
  // the product written to out_o includes the last partial product.
  logic                step_en;
  logic [W-1:0]        acc_next;
  logic [W-1:0]        b_next;
  logic                last_step;

  assign step_en  = (div_cnt == DIV_LAST);
  assign acc_next = b_reg[0] ? (acc + a_reg) : acc;
  assign b_next   = b_reg >> 1;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  // Once no multiplier bits remain, further steps cannot change acc.
  assign last_step = (step_cnt == STEP_LAST) || (b_next == '0);
`else
  assign last_step = (step_cnt == STEP_LAST);
`endif

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      a_reg           <= '0;
      b_reg           <= '0;
      acc             <= '0;
      step_cnt        <= '0;
      div_cnt         <= '0;
      out_o           <= '0;
      MUL_Done_STRB_o <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      MUL_Done_STRB_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (MUL_Start_STRB_i) begin
            a_reg    <= a_i;
            b_reg    <= b_i;
            acc      <= '0;
            step_cnt <= '0;
            div_cnt  <= '0;
            busy_o   <= 1'b1;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (!step_en) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt  <= '0;
            acc      <= acc_next;
            a_reg    <= a_reg << 1;
            b_reg    <= b_next;
            step_cnt <= step_cnt + STEP_W'(1);
            if (last_step) begin
              out_o           <= acc_next;
              MUL_Done_STRB_o <= 1'b1;
              busy_o          <= 1'b0;
              state           <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_responder.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_responder
//
// Self-checking bench for seq_mul_responder with N=4 (8-bit operands) and
// CLK_DIV_MULTIPLIER=2. Inputs are driven before each rising edge; a small
// transaction-level model predicts busy/done/out for that edge and accepted
// operations are pushed to a scoreboard queue. Outputs are checked on the
// following falling edge; each done strobe pops the scoreboard and compares
// the product and the completion edge.
// -----------------------------------------------------------------------------
module tb_seq_mul_responder;

  localparam int N   = 4;
  localparam int W   = 2 * N;
  localparam int DIV = 2;

  typedef struct {
    logic [W-1:0] prod;
    int           done_at;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         done;
  logic         busy;
  logic [W-1:0] out;

  seq_mul_responder #(
    .N                  (N),
    .CLK_DIV_MULTIPLIER (DIV)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .MUL_Start_STRB_i (start),
    .a_i              (a),
    .b_i              (b),
    .MUL_Done_STRB_o  (done),
    .busy_o           (busy),
    .out_o            (out)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard and model state
  exp_t         sb[$];
  int           n_checks  = 0;
  int           n_pass    = 0;
  int           edge_n    = 0;
  logic         m_active  = 1'b0;
  logic         m_done    = 1'b0;
  logic [W-1:0] m_out     = '0;
  logic [W-1:0] m_prod    = '0;
  int           m_done_at = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, got, exp);
  endtask

  // Clock cycles from the accepting edge to the done edge.
  function automatic int latency(input logic [W-1:0] bv);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    int h;
    h = 1;
    for (int i = 0; i < W; i++) if (bv[i]) h = i + 1;
    return h * DIV;
`else
    return W * DIV;
`endif
  endfunction

  // One clock: drive inputs, predict the edge, check outputs at the falling edge.
  task automatic cycle(input logic r, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    rst_i = r;
    start = s;
    a     = av;
    b     = bv;
    @(posedge clk_i);
    edge_n++;
    m_done = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_out    = '0;
      sb.delete();
    end else if (m_active && edge_n == m_done_at) begin
      m_active = 1'b0;
      m_out    = m_prod;
      m_done   = 1'b1;
    end else if (!m_active && s) begin
      m_active  = 1'b1;
      m_done_at = edge_n + latency(bv);
      m_prod    = av * bv;
      e.prod    = m_prod;
      e.done_at = m_done_at;
      sb.push_back(e);
    end
    @(negedge clk_i);
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("out_hold", 32'(out), 32'(m_out));
    if (done === 1'b1) begin
      check("sb_depth_at_done", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_product", 32'(out), 32'(e.prod));
        check("sb_latency_edge", 32'(edge_n), 32'(e.done_at));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic go(input logic [W-1:0] av, input logic [W-1:0] bv);
    cycle(1'b0, 1'b1, av, bv);
  endtask

  initial begin
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 8'h12, 8'h34);
    idle(2);

    // Basic products, including negative operand and wrap-around
    go(8'd3, 8'd5);     idle(20);
    go(8'hFD, 8'd5);    idle(20);
    go(8'h80, 8'hFF);   idle(20);

    // Second start while busy is ignored
    go(8'd7, 8'd9);     idle(4);
    go(8'd1, 8'd1);     idle(20);

    // Reset in the middle of an operation
    go(8'd6, 8'd6);     idle(7);
    cycle(1'b1, 1'b0, 8'd6, 8'd6);
    idle(20);

    // Start held high: back-to-back operations, start coincides with IDLE after done
    cycle(1'b0, 1'b1, 8'd2, 8'd3);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 8'd4, 8'd4);
    idle(20);

    // Early-exit boundary operands (fixed latency in the default build)
    go(8'd5, 8'd1);     idle(20);
    go(8'd5, 8'd0);     idle(20);
    go(8'd1, 8'h80);    idle(20);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      go(W'($urandom), W'($urandom));
      idle(20);
    end

    // Bounded drain of anything still in flight
    for (int i = 0; i < 100 && m_active; i++) idle(1);
    check("sb_empty_at_end", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
